// File: rtl/cpu_paddle_driver.sv
// rtl/cpu_paddle_driver.sv - CPU opponent that drives a players_logic button word from ball and paddle positions
module cpu_paddle_driver #(
  parameter int CLK_HZ      = 10_000_000,
  parameter int DECIDE_HZ   = 50,
  parameter int REACT_TICKS = 3,
  parameter int DEADBAND    = 2,
  parameter int HOME_POS    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [6:0] ball_x,
  input  logic       ball_incoming,
  input  logic [6:0] paddle_pos,
  output logic [1:0] btns
);

  localparam int CUENTA = CLK_HZ / DECIDE_HZ;
  localparam int CW     = $clog2(CUENTA);
  localparam logic [CW-1:0] LAST_CNT = CW'(CUENTA - 1);
  localparam logic [6:0] HOME       = 7'(HOME_POS);
  localparam logic [6:0] EXIT_BAND  = 7'(DEADBAND);
  localparam logic [6:0] ENTRY_BAND = 7'(2 * DEADBAND);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_SEEK_L = 2'd2;
  localparam logic [1:0] S_SEEK_R = 2'd3;

  logic [CW-1:0]     cont_q, cont_d;
  logic              tick;
  logic [6:0]        line_q [REACT_TICKS];
  logic [6:0]        goal;
  logic [6:0]        target;
  logic signed [7:0] diff;
  logic              diff_pos;
  logic [6:0]        mag;
  logic [1:0]        state_q, state_d;
  logic [1:0]        btns_q, btns_d;

  // Decision-rate tick: one cycle high at the end of each counter period
  always_comb begin
    tick   = (cont_q == LAST_CNT);
    cont_d = tick ? '0 : cont_q + CW'(1);
  end

  // Goal selection and error against the delayed target
  always_comb begin
    goal     = ball_incoming ? ball_x : HOME;
    target   = line_q[REACT_TICKS-1];
    diff     = $signed({1'b0, target}) - $signed({1'b0, paddle_pos});
    diff_pos = !diff[7] && (diff != 8'sd0);
    // |diff| fits in 7 bits since diff never reaches -128
    mag      = diff[7] ? (7'd0 - diff[6:0]) : diff[6:0];
  end

  // Hysteresis FSM: wide entry band to start seeking, narrow exit band to stop
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else if (tick) begin
      case (state_q)
        S_IDLE: state_d = S_HOLD;
        S_HOLD: begin
          if (mag > ENTRY_BAND) state_d = diff_pos ? S_SEEK_R : S_SEEK_L;
        end
        S_SEEK_L: begin
          if (mag <= EXIT_BAND) state_d = S_HOLD;
          else if (diff_pos)    state_d = S_SEEK_R;
        end
        S_SEEK_R: begin
          if (mag <= EXIT_BAND) state_d = S_HOLD;
          else if (diff[7])     state_d = S_SEEK_L;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Button decode from the next state so btns is registered alongside the state
  always_comb begin
    case (state_d)
      S_SEEK_L: btns_d = 2'b01;
      S_SEEK_R: btns_d = 2'b10;
      default:  btns_d = 2'b00;
    endcase
  end

  // State, counter and reaction delay line; reset wins over a coincident tick
  always_ff @(posedge clk) begin
    if (rst) begin
      cont_q  <= '0;
      state_q <= S_IDLE;
      btns_q  <= 2'b00;
      for (int i = 0; i < REACT_TICKS; i++) line_q[i] <= HOME;
    end else begin
      cont_q  <= cont_d;
      state_q <= state_d;
      btns_q  <= btns_d;
      if (tick) begin
        for (int i = REACT_TICKS - 1; i > 0; i--) line_q[i] <= line_q[i-1];
        line_q[0] <= goal;
      end
    end
  end

  assign btns = btns_q;

endmodule

// File: tb/tb_cpu_paddle_driver.sv
// tb/tb_cpu_paddle_driver.sv - self-checking bench for cpu_paddle_driver
module tb_cpu_paddle_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [6:0] ball_x;
  logic       ball_incoming;
  logic [6:0] paddle_pos;
  logic [1:0] btns;

  int total = 0;
  int bad   = 0;

  // reference model state
  int         m_cyc;
  int         m_hist[$];
  bit         m_active;
  int         m_dir;
  logic [1:0] m_btns;

  always #5 clk = ~clk;

  cpu_paddle_driver #(
    .CLK_HZ(1000), .DECIDE_HZ(100), .REACT_TICKS(3), .DEADBAND(2), .HOME_POS(64)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ball_x(ball_x),
    .ball_incoming(ball_incoming), .paddle_pos(paddle_pos), .btns(btns)
  );

  task automatic chk(input string tag, input logic [1:0] exp);
    total++;
    assert (btns === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, btns, exp);
    end
  endtask

  // Behavioural model: one call per clock, using the inputs present before the edge
  task automatic model_step();
    bit tick;
    int tgt, d, a;
    if (rst) begin
      m_cyc = 0;
      m_hist.delete();
      repeat (3) m_hist.push_back(64);
      m_active = 0;
      m_dir = 0;
    end else begin
      tick = (m_cyc % 10) == 9;
      d = 0;
      a = 0;
      if (tick) begin
        tgt = m_hist.pop_front();
        m_hist.push_back(ball_incoming ? int'(ball_x) : 64);
        d = tgt - int'(paddle_pos);
        a = (d < 0) ? -d : d;
      end
      if (!enable) begin
        m_active = 0;
        m_dir = 0;
      end else if (tick) begin
        if (!m_active) begin
          m_active = 1;
          m_dir = 0;
        end else if (m_dir == 0) begin
          if (a > 4) m_dir = (d > 0) ? 1 : -1;
        end else if (a <= 2) begin
          m_dir = 0;
        end else if (d * m_dir < 0) begin
          m_dir = -m_dir;
        end
      end
      m_cyc++;
    end
    m_btns = (!m_active || m_dir == 0) ? 2'b00 : ((m_dir < 0) ? 2'b01 : 2'b10);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("model", m_btns);
    total++;
    assert (btns !== 2'b11) else begin
      bad++;
      $error("FAIL never_11 observed=%b expected=not 11", btns);
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic to_phase(input int p);
    repeat (10) if ((m_cyc % 10) != p) cyc();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; ball_incoming = 1'b1; ball_x = 7'd10; paddle_pos = 7'd64;
    run(3);
    chk("reset_btns", 2'b00);
    rst = 1'b0;
    run(25);
    chk("disabled_idle", 2'b00);

    // seek left
    ball_x = 7'd40; enable = 1'b1;
    run(70);
    chk("seek_left", 2'b01);
    run(30);
    chk("seek_left_hold", 2'b01);

    // settle and hysteresis around target 50
    ball_x = 7'd50; paddle_pos = 7'd30;
    run(60);
    chk("seek_right", 2'b10);
    paddle_pos = 7'd47; run(10); chk("mag3_stays", 2'b10);
    paddle_pos = 7'd48; run(10); chk("mag2_settles", 2'b00);
    paddle_pos = 7'd46; run(10); chk("mag4_holds", 2'b00);
    paddle_pos = 7'd45; run(10); chk("mag5_seeks", 2'b10);

    // home return
    ball_incoming = 1'b0; paddle_pos = 7'd20;
    run(40);
    chk("home_seek", 2'b10);
    paddle_pos = 7'd61; run(10); chk("home_61", 2'b10);
    paddle_pos = 7'd62; run(10); chk("home_62", 2'b00);

    // disable mid-seek, then re-enable
    paddle_pos = 7'd20;
    run(10);
    chk("pre_disable", 2'b10);
    to_phase(3);
    enable = 1'b0;
    run(1);
    chk("disable_next_edge", 2'b00);
    run(5);
    enable = 1'b1;
    run(10);
    chk("reenable_one_tick", 2'b00);
    run(1);
    chk("reenable_two_ticks", 2'b10);

    // extremes
    ball_incoming = 1'b1; ball_x = 7'd127; paddle_pos = 7'd0;
    run(50);
    chk("extreme_right", 2'b10);
    ball_x = 7'd0; paddle_pos = 7'd127;
    run(50);
    chk("extreme_left", 2'b01);

    // reset asserted on a tick cycle
    to_phase(9);
    rst = 1'b1;
    run(1);
    chk("reset_on_tick", 2'b00);
    rst = 1'b0;
    run(15);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 7) == 0) paddle_pos = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 29) == 0) begin
        ball_x = 7'($urandom_range(0, 127));
        ball_incoming = ($urandom_range(0, 3) != 0);
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
